// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter and burst sequencer in front of the unified memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: contested grants alternate; otherwise data beats fetch.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [1:0]  if_size,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_rd_wr,
    input  logic [31:0] d_wdata,
    output logic        d_wready,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rd_wr,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy
);
    localparam int unsigned CNT_W = 4;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]       state, state_d;
    logic             owner, owner_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             if_gnt_d, if_rvalid_d, if_done_d;
    logic             d_gnt_d, d_rvalid_d, d_done_d;
    logic             mem_enable_d, mem_rd_wr_d;
    logic [31:0]      mem_addr_d;
    logic             accept;
    logic             pick_data;

    function automatic logic [CNT_W-1:0] beats_minus_one(input logic [1:0] size);
        case (size)
            2'd0:    return CNT_W'(0);
            2'd1:    return CNT_W'(3);
            2'd2:    return CNT_W'(7);
            default: return CNT_W'(15);
        endcase
    endfunction

    assign accept = mem_enable & ~mem_busy;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer moves only on contested grants so a lone requester never skews the next tie-break.
    logic last_data, last_data_d;
    assign pick_data = d_req & (~if_req | ~last_data);
`else
    assign pick_data = d_req;
`endif

    // Read data is steered straight from memory to the port that owns the returning beat.
    assign if_rdata        = if_rvalid ? mem_data_out : 32'd0;
    assign d_rdata         = d_rvalid ? mem_data_out : 32'd0;
    assign d_wready        = accept & owner & ~mem_rd_wr;
    assign mem_data_in     = (mem_enable & ~mem_rd_wr) ? d_wdata : 32'd0;
    assign mem_access_size = 2'b00;

    always_comb begin
        state_d      = state;
        owner_d      = owner;
        cnt_d        = cnt;
        mem_enable_d = mem_enable;
        mem_addr_d   = mem_addr;
        mem_rd_wr_d  = mem_rd_wr;
        if_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        if_done_d    = 1'b0;
        d_gnt_d      = 1'b0;
        d_rvalid_d   = 1'b0;
        d_done_d     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_data_d  = last_data;
`endif
        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    state_d      = BURST;
                    owner_d      = pick_data;
                    d_gnt_d      = pick_data;
                    if_gnt_d     = ~pick_data;
                    mem_enable_d = 1'b1;
                    mem_addr_d   = pick_data ? d_addr : if_addr;
                    mem_rd_wr_d  = pick_data ? d_rd_wr : 1'b1;
                    cnt_d        = beats_minus_one(pick_data ? d_size : if_size);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (d_req && if_req) last_data_d = pick_data;
`endif
                end
            end
            BURST: begin
                if (accept) begin
                    if (mem_rd_wr) begin
                        d_rvalid_d  = owner;
                        if_rvalid_d = ~owner;
                    end
                    if (cnt == '0) begin
                        mem_enable_d = 1'b0;
                        d_done_d     = owner;
                        if_done_d    = ~owner;
                        state_d      = mem_rd_wr ? RESP : IDLE;
                    end else begin
                        cnt_d      = cnt - CNT_W'(1);
                        mem_addr_d = mem_addr + 32'd4;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            mem_enable <= 1'b0;
            mem_addr   <= 32'd0;
            mem_rd_wr  <= 1'b0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_done    <= 1'b0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_done     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data  <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            cnt        <= cnt_d;
            mem_enable <= mem_enable_d;
            mem_addr   <= mem_addr_d;
            mem_rd_wr  <= mem_rd_wr_d;
            if_gnt     <= if_gnt_d;
            if_rvalid  <= if_rvalid_d;
            if_done    <= if_done_d;
            d_gnt      <= d_gnt_d;
            d_rvalid   <= d_rvalid_d;
            d_done     <= d_done_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data  <= last_data_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: word-memory environment plus a time-driven reference of each burst.
module tb_mem_arbiter;
    logic        clk;
    logic        reset_n;
    logic        if_req, if_gnt, if_rvalid, if_done;
    logic [31:0] if_addr, if_rdata;
    logic [1:0]  if_size;
    logic        d_req, d_rd_wr, d_wready, d_gnt, d_rvalid, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        mem_enable, mem_rd_wr, mem_busy;
    logic [31:0] mem_addr, mem_data_in;
    logic [31:0] mem_data_out = 32'd0;
    logic [1:0]  mem_access_size;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rnd_busy = 0;
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_size(if_size), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_rd_wr(d_rd_wr),
        .d_wdata(d_wdata), .d_wready(d_wready), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_access_size(mem_access_size), .mem_rd_wr(mem_rd_wr),
        .mem_data_out(mem_data_out), .mem_busy(mem_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3c3c_a5a5;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory environment: read data appears the cycle after an accepted read beat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_enable && !mem_busy) begin
            if (mem_rd_wr)
                mem_data_out <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_word(mem_addr);
            else
                mem_store[mem_addr] = mem_data_in;
        end
    end

    function automatic logic [127:0] all_outputs();
        return {if_gnt, if_rvalid, if_done, if_rdata, d_gnt, d_rvalid, d_done, d_wready,
                d_rdata, mem_enable, mem_rd_wr, mem_access_size, mem_addr[23:0], mem_data_in[19:0]};
    endfunction

    task automatic run_burst(input string name, input bit dport, input logic [31:0] base,
                             input logic [1:0] size, input bit rd, input int stall_beat,
                             input int stall_len, input logic [31:0] w0);
        int n, t, acc, nstall, stalled, done_cyc, act_done, act_rv, c;
        bit prev_acc, exp_en, exp_acc, exp_rv, exp_done, seen_gnt, finished;
        logic [31:0] prev_addr, exp_addr, o_rdata;
        logic o_gnt, o_rv, o_done;
        logic [34:0] x_bus;
        logic [31:0] wdata [16];
        n = (size == 2'd0) ? 1 : (1 << (int'(size) + 1));
        for (int i = 0; i < 16; i++) wdata[i] = $urandom;
        wdata[0] = w0;
        acc = 0; nstall = 0; stalled = 0; done_cyc = -1; act_done = -1; act_rv = 0;
        prev_acc = 0; seen_gnt = 0; finished = 0; prev_addr = '0;
        @(negedge clk);
        t = cyc;
        if (dport) begin d_req = 1; d_addr = base; d_size = size; d_rd_wr = rd; end
        else begin if_req = 1; if_addr = base; if_size = size; end
        for (c = t; c <= t + 200 && !finished; c++) begin
            if (c != t) @(negedge clk);
            exp_en = (c >= t + 1) && (acc < n);
            if (seen_gnt) begin d_req = 0; if_req = 0; end
            if (exp_en && acc == stall_beat && stalled < stall_len) begin
                mem_busy = 1'b1;
                stalled++;
            end else begin
                mem_busy = rnd_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            d_wdata  = wdata[(acc < n) ? acc : 0];
            if (exp_en && mem_busy) nstall++;
            exp_acc  = exp_en && !mem_busy;
            exp_addr = base + 32'(4 * acc);
            exp_rv   = prev_acc && rd;
            exp_done = prev_acc && (acc == n);
            #1;
            o_gnt   = dport ? d_gnt : if_gnt;
            o_rv    = dport ? d_rvalid : if_rvalid;
            o_rdata = dport ? d_rdata : if_rdata;
            o_done  = dport ? d_done : if_done;
            x_bus   = dport ? {if_gnt, if_rvalid, if_done, if_rdata} : {d_gnt, d_rvalid, d_done, d_rdata};
            if (o_gnt) seen_gnt = 1;
            if (o_rv) act_rv++;
            if (o_done && act_done < 0) act_done = c;
            checks++;
            if (o_gnt !== (c == t + 1)) begin
                failures++;
                $display("FAIL %s gnt cyc+%0d got=%b exp=%b", name, c - t, o_gnt, c == t + 1);
            end
            checks++;
            if (mem_enable !== exp_en) begin
                failures++;
                $display("FAIL %s mem_enable cyc+%0d got=%b exp=%b", name, c - t, mem_enable, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (mem_addr !== exp_addr || mem_rd_wr !== rd) begin
                    failures++;
                    $display("FAIL %s beat%0d addr/dir got=%h/%b exp=%h/%b", name, acc, mem_addr, mem_rd_wr, exp_addr, rd);
                end
                if (!rd) begin
                    checks++;
                    if (mem_data_in !== wdata[acc]) begin
                        failures++;
                        $display("FAIL %s beat%0d mem_data_in got=%h exp=%h", name, acc, mem_data_in, wdata[acc]);
                    end
                end
            end
            checks++;
            if (d_wready !== (exp_acc && !rd && dport)) begin
                failures++;
                $display("FAIL %s d_wready cyc+%0d got=%b exp=%b", name, c - t, d_wready, exp_acc && !rd && dport);
            end
            checks++;
            if (o_rv !== exp_rv || (exp_rv && o_rdata !== ref_word(prev_addr))) begin
                failures++;
                $display("FAIL %s rvalid/rdata cyc+%0d got=%b/%h exp=%b/%h", name, c - t, o_rv, o_rdata, exp_rv, ref_word(prev_addr));
            end
            checks++;
            if (o_done !== exp_done) begin
                failures++;
                $display("FAIL %s done cyc+%0d got=%b exp=%b", name, c - t, o_done, exp_done);
            end
            checks++;
            if (x_bus !== 35'd0) begin
                failures++;
                $display("FAIL %s idle_port cyc+%0d got=%h exp=0", name, c - t, x_bus);
            end
            prev_acc = exp_acc;
            if (exp_acc) begin
                if (!rd) ref_mem[exp_addr] = wdata[acc];
                prev_addr = exp_addr;
                acc++;
            end
            if (exp_done) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 1) finished = 1;
        end
        d_req = 0; if_req = 0; mem_busy = 0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s timeout got=unfinished exp=finished", name);
        end
        checks++;
        if (act_done != t + n + 1 + nstall) begin
            failures++;
            $display("FAIL %s done_time got=T+%0d exp=T+%0d", name, act_done - t, n + 1 + nstall);
        end
        checks++;
        if (act_rv != (rd ? n : 0)) begin
            failures++;
            $display("FAIL %s rvalid_count got=%0d exp=%0d", name, act_rv, rd ? n : 0);
        end
    endtask

    task automatic test_reset();
        reset_n = 0; if_req = 0; d_req = 0; mem_busy = 0; d_rd_wr = 0; d_wdata = 0;
        if_addr = 0; if_size = 0; d_addr = 0; d_size = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_outputs());
        end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_fetch_burst();
        run_burst("fetch4", 0, 32'h8002_0000, 2'd1, 1, -1, 0, 32'd0);
    endtask

    task automatic test_write_readback();
        run_burst("write1", 1, 32'h8002_0003, 2'd0, 0, -1, 0, 32'haaaa_eeee);
        run_burst("readback1", 1, 32'h8002_0003, 2'd0, 1, -1, 0, 32'd0);
    endtask

    task automatic test_pair(input string name, input bit expect_data_first);
        int t, dg, ig, dd, id, drv, irv, both, fg, fd, sg, sd;
        dg = -1; ig = -1; dd = -1; id = -1; drv = 0; irv = 0; both = 0;
        @(negedge clk);
        t = cyc;
        d_req = 1; d_rd_wr = 1; d_size = 2'd1; d_addr = $urandom;
        if_req = 1; if_size = 2'd1; if_addr = $urandom;
        mem_busy = 0;
        for (int c = t; c <= t + 40; c++) begin
            if (c != t) @(negedge clk);
            if (dg >= 0) d_req = 0;
            if (ig >= 0) if_req = 0;
            #1;
            if (d_gnt && if_gnt) both++;
            if (d_gnt && dg < 0) dg = c;
            if (if_gnt && ig < 0) ig = c;
            if (d_done && dd < 0) dd = c;
            if (if_done && id < 0) id = c;
            if (d_rvalid) drv++;
            if (if_rvalid) irv++;
        end
        d_req = 0; if_req = 0;
        fg = expect_data_first ? dg : ig;  fd = expect_data_first ? dd : id;
        sg = expect_data_first ? ig : dg;  sd = expect_data_first ? id : dd;
        checks++;
        if (fg != t + 1 || fd != t + 5) begin
            failures++;
            $display("FAIL %s first_port gnt/done got=T+%0d/T+%0d exp=T+1/T+5", name, fg - t, fd - t);
        end
        checks++;
        if (sg != t + 7 || sd != t + 11) begin
            failures++;
            $display("FAIL %s second_port gnt/done got=T+%0d/T+%0d exp=T+7/T+11", name, sg - t, sd - t);
        end
        checks++;
        if (drv != 4 || irv != 4 || both != 0) begin
            failures++;
            $display("FAIL %s pulses d_rv/if_rv/dual_gnt got=%0d/%0d/%0d exp=4/4/0", name, drv, irv, both);
        end
    endtask

    task automatic test_arbitration();
        test_pair("pair1", 1'b1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        test_pair("pair2", 1'b0);
`else
        test_pair("pair2", 1'b1);
`endif
    endtask

    task automatic test_busy();
        run_burst("busy8", 0, 32'h8002_0000, 2'd2, 1, 1, 2, 32'd0);
    endtask

    task automatic test_wrap();
        run_burst("wrap4", 1, 32'hFFFF_FFF8, 2'd1, 1, -1, 0, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] base, last_base;
        bit dport, rd;
        last_base = 32'h1000_0000;
        rnd_busy = 1;
        for (int i = 0; i < 12; i++) begin
            dport = 1'($urandom_range(0, 1));
            rd    = dport ? 1'($urandom_range(0, 1)) : 1'b1;
            base  = (i % 3 == 2) ? last_base : $urandom;
            run_burst("random", dport, base, 2'($urandom_range(0, 3)), rd, -1, 0, $urandom);
            if (!rd) last_base = base;
        end
        rnd_busy = 0;
    endtask

    task automatic test_reset_midburst();
        bit found;
        found = 0;
        @(negedge clk);
        if_req = 1; if_addr = 32'h8002_0100; if_size = 2'd3;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (if_gnt) if_req = 0;
            if (mem_enable && mem_addr == 32'h8002_0114) found = 1;
        end
        if_req = 0;
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midburst_reach_beat5 got=not_reached exp=reached");
        end
        reset_n = 0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            failures++;
            $display("FAIL midburst_reset_async got=%h exp=0", all_outputs());
        end
        @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            failures++;
            $display("FAIL midburst_reset_held got=%h exp=0", all_outputs());
        end
        reset_n = 1;
        @(negedge clk);
        run_burst("after_reset", 0, 32'h8002_0200, 2'd1, 1, -1, 0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_fetch_burst();
        test_write_readback();
        test_arbitration();
        test_busy();
        test_wrap();
        test_random();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
